// File: rtl/flag_shadow_ctrl_if.sv
// Flag/interrupt bundle between the ALU/decoder side and the flag shadow controller.
// The master drives ALU results, flag strobes and INT_REQ; the slave returns registered flags and ISR status.
interface flag_shadow_ctrl_if;
  logic C_IN;
  logic Z_IN;
  logic FLG_C_LD;
  logic FLG_Z_LD;
  logic FLG_C_SET;
  logic FLG_C_CLR;
  logic I_SET;
  logic I_CLR;
  logic INT_REQ;
  logic RETI;
  logic RETI_IE;
  logic C_FLAG;
  logic Z_FLAG;
  logic I_FLAG;
  logic SHAD_C;
  logic SHAD_Z;
  logic FLG_LD_SEL;
  logic INT_ACK;
  logic IN_ISR;

  modport master (
    output C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR,
           I_SET, I_CLR, INT_REQ, RETI, RETI_IE,
    input  C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, FLG_LD_SEL, INT_ACK, IN_ISR
  );

  modport slave (
    input  C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR,
           I_SET, I_CLR, INT_REQ, RETI, RETI_IE,
    output C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, FLG_LD_SEL, INT_ACK, IN_ISR
  );
endinterface

// File: rtl/flag_shadow_ctrl.sv
// C/Z/I flag register with single-level interrupt shadowing; INT_ACK follows synchronized INT_REQ
// by SYNC_STAGES+1 cycles, flags restore on the edge after RETI; no backpressure, nesting is refused.
module flag_shadow_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input logic               CLK,
  input logic               RST_N,
  flag_shadow_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    ISR     = 2'd2,
    RESTORE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   c_flag_q, c_flag_d;
  logic                   z_flag_q, z_flag_d;
  logic                   i_flag_q, i_flag_d;
  logic                   shad_c_q, shad_c_d;
  logic                   shad_z_q, shad_z_d;
  logic                   reti_ie_q, reti_ie_d;
  logic                   int_s;
  logic                   int_ack;
  logic                   flg_ld_sel;
  logic                   in_isr;

  assign int_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      c_flag_q  <= 1'b0;
      z_flag_q  <= 1'b0;
      i_flag_q  <= 1'b0;
      shad_c_q  <= 1'b0;
      shad_z_q  <= 1'b0;
      reti_ie_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      c_flag_q  <= c_flag_d;
      z_flag_q  <= z_flag_d;
      i_flag_q  <= i_flag_d;
      shad_c_q  <= shad_c_d;
      shad_z_q  <= shad_z_d;
      reti_ie_q <= reti_ie_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (int_s && i_flag_q) state_d = SAVE;
      SAVE:    state_d = ISR;
      ISR:     if (bus.RETI) state_d = RESTORE;
      RESTORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int_ack    = (state_q == SAVE);
    flg_ld_sel = (state_q == RESTORE);
    in_isr     = (state_q != IDLE);
  end

  always_comb begin
    sync_d[0] = bus.INT_REQ;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    c_flag_d  = c_flag_q;
    z_flag_d  = z_flag_q;
    i_flag_d  = i_flag_q;
    shad_c_d  = shad_c_q;
    shad_z_d  = shad_z_q;
    reti_ie_d = reti_ie_q;

    if (flg_ld_sel) begin
      c_flag_d = shad_c_q;
      z_flag_d = shad_z_q;
      i_flag_d = reti_ie_q;
    end else begin
      if (bus.FLG_C_CLR)     c_flag_d = 1'b0;
      else if (bus.FLG_C_SET) c_flag_d = 1'b1;
      else if (bus.FLG_C_LD)  c_flag_d = bus.C_IN;

      if (bus.FLG_Z_LD) z_flag_d = bus.Z_IN;

      if (bus.I_CLR)      i_flag_d = 1'b0;
      else if (bus.I_SET) i_flag_d = 1'b1;
    end

    // Entry into the ISR snapshots the pre-edge flags and masks further interrupts.
    if (int_ack) begin
      shad_c_d = c_flag_q;
      shad_z_d = z_flag_q;
      i_flag_d = 1'b0;
    end

    // The restored I value is the one presented alongside RETI, not whatever follows it.
    if (state_q == ISR && bus.RETI) reti_ie_d = bus.RETI_IE;
  end

  assign bus.C_FLAG     = c_flag_q;
  assign bus.Z_FLAG     = z_flag_q;
  assign bus.I_FLAG     = i_flag_q;
  assign bus.SHAD_C     = shad_c_q;
  assign bus.SHAD_Z     = shad_z_q;
  assign bus.FLG_LD_SEL = flg_ld_sel;
  assign bus.INT_ACK    = int_ack;
  assign bus.IN_ISR     = in_isr;

endmodule

// File: doc/flag_shadow_ctrl.md
FLAG_SHADOW_CTRL -- requirements
Module: flag_shadow_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of INT_REQ synchronizer flops (legal range 1..4).
REQ-002 SHALL have port CLK  in  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports C_IN, Z_IN  in  1 each  carry and zero results from the ALU.
REQ-005 SHALL have ports FLG_C_LD, FLG_Z_LD  in  1 each  load C_IN/Z_IN into the C/Z flags.
REQ-006 SHALL have ports FLG_C_SET, FLG_C_CLR  in  1 each  force C to 1 or 0.
REQ-007 SHALL have ports I_SET, I_CLR  in  1 each  set or clear the interrupt-enable flag.
REQ-008 SHALL have port INT_REQ  in  1  external interrupt request, asynchronous, level.
REQ-009 SHALL have ports RETI, RETI_IE  in  1 each  return-from-ISR strobe; RETI_IE is the I value to restore.
REQ-010 SHALL have ports C_FLAG, Z_FLAG, I_FLAG  out  1 each  registered flag values.
REQ-011 SHALL have ports SHAD_C, SHAD_Z  out  1 each  registered shadow flags.
REQ-012 SHALL have port FLG_LD_SEL  out  1  high only in RESTORE; selects shadow source for the flag muxes.
REQ-013 SHALL have ports INT_ACK, IN_ISR  out  1 each  one-cycle acknowledge pulse; high while ISR active.

Function
REQ-014 SHALL pass INT_REQ through SYNC_STAGES flops; only the last stage (int_s) is used.
REQ-015 SHALL implement FSM states IDLE, SAVE, ISR, RESTORE.
REQ-016 IDLE -> SAVE when int_s=1 and I_FLAG=1; otherwise stay IDLE.
REQ-017 SAVE lasts exactly one cycle: SHAD_C<=C_FLAG, SHAD_Z<=Z_FLAG, I_FLAG<=0, INT_ACK=1; then -> ISR.
REQ-018 ISR: IN_ISR=1; a new int_s is ignored (no nesting); RETI=1 -> RESTORE.
REQ-019 RESTORE lasts one cycle: FLG_LD_SEL=1, C_FLAG<=SHAD_C, Z_FLAG<=SHAD_Z, I_FLAG<=RETI_IE sampled in the ISR cycle that asserted RETI; then -> IDLE.
REQ-020 RETI in IDLE or SAVE SHALL be ignored (no state or flag change).
REQ-021 C update priority, outside SAVE/RESTORE: FLG_C_CLR > FLG_C_SET > FLG_C_LD > hold.
REQ-022 Z update outside SAVE/RESTORE: FLG_Z_LD loads Z_IN, else hold.
REQ-023 I update outside SAVE/RESTORE: I_CLR > I_SET > hold.
REQ-024 In SAVE, C/Z load, set and clear inputs SHALL apply normally; SHAD_* captures the pre-edge values.
REQ-025 In SAVE, I_SET is overridden by the forced clear.
REQ-026 In RESTORE, all flag load/set/clear inputs SHALL be ignored.
REQ-027 Latency: int_s rising in IDLE with I=1 -> INT_ACK one cycle later; RETI -> flags restored at the next edge.
REQ-028 IN_ISR SHALL be 1 in SAVE, ISR and RESTORE, and 0 in IDLE.

Reset
REQ-029 RST_N=0 at a clock edge SHALL force state IDLE, all flags, shadows and sync flops to 0, and INT_ACK and FLG_LD_SEL to 0.
REQ-030 Reset SHALL win over every other input, including reset asserted mid-SAVE, mid-ISR or mid-RESTORE; after reset, I=0, so no interrupt is taken until I_SET.

Verification
REQ-031 Reset then I_SET, C_IN=1 with FLG_C_LD, Z_IN=1 with FLG_Z_LD, INT_REQ=1 -> INT_ACK after SYNC_STAGES+1 cycles, SHAD_C=1, SHAD_Z=1, I_FLAG=0.
REQ-032 In ISR, clear C and Z via the ALU, then RETI with RETI_IE=1 -> FLG_LD_SEL pulses one cycle, then C=1, Z=1, I=1, state IDLE.
REQ-033 INT_REQ held with I_FLAG=0 for 10 cycles -> no INT_ACK; I_SET -> INT_ACK within SYNC_STAGES+2 cycles.
REQ-034 INT_REQ re-asserted in ISR, then RETI with RETI_IE=0 -> no second INT_ACK, I=0 after restore.
REQ-035 FLG_C_SET, FLG_C_CLR and FLG_C_LD asserted together with C_IN=1 -> C=0; RETI pulsed in IDLE -> no change.
REQ-036 RST_N=0 during RESTORE -> next cycle all outputs 0, state IDLE, shadow contents lost.
